// File: rtl/mul_pkg.sv
// mul_pkg: definitions shared by the Booth multiplier request sequencer.
//   OPW   operand width of the signed multiplier datapath
//   RESW  product width
//   WDW   watchdog counter width
//   seq_state_e  sequencer FSM states
package mul_pkg;

    localparam int OPW  = 64;
    localparam int RESW = 128;
    localparam int WDW  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_CLEAR = 2'd3
    } seq_state_e;

endpackage

// File: rtl/mul_req_fifo.sv
// mul_req_fifo: synchronous request FIFO holding {tag, multiplicand, multiplier}.
// The head entry is shown continuously on the head_* outputs.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   push, push_*         write an entry (ignored when full)
//   pop                  drop the head entry (ignored when empty)
//   head_*               current head entry
//   full, empty, count   occupancy, all derived from the registered count
module mul_req_fifo
    import mul_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int TAG_W = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [TAG_W-1:0] push_tag,
    input  logic [OPW-1:0]   push_multiplicand,
    input  logic [OPW-1:0]   push_multiplier,
    input  logic             pop,
    output logic [TAG_W-1:0] head_tag,
    output logic [OPW-1:0]   head_multiplicand,
    output logic [OPW-1:0]   head_multiplier,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [TAG_W-1:0] mem_tag          [DEPTH];
    logic [OPW-1:0]   mem_multiplicand [DEPTH];
    logic [OPW-1:0]   mem_multiplier   [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign head_tag          = mem_tag[rd_ptr];
    assign head_multiplicand = mem_multiplicand[rd_ptr];
    assign head_multiplier   = mem_multiplier[rd_ptr];

    // Storage, pointers and count. DEPTH is a power of two, so the pointers
    // wrap modulo DEPTH by natural overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_tag[i]          <= '0;
                mem_multiplicand[i] <= '0;
                mem_multiplier[i]   <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem_tag[wr_ptr]          <= push_tag;
                mem_multiplicand[wr_ptr] <= push_multiplicand;
                mem_multiplier[wr_ptr]   <= push_multiplier;
                wr_ptr                   <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: request sequencer for the radix-2 Booth multiplier.
// Buffers requests in mul_req_fifo, starts the multiplier on the FIFO head,
// collects the product and returns it with its tag. A watchdog turns an
// operation with no op_done into an error response (result 0, rsp_err 1).
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   req_valid/req_ready/req_*       request channel
//   op_start, op_clear              one-cycle control pulses to the multiplier
//   multiplier, multiplicand        operands of the FIFO head
//   op_done, result                 multiplier status and product
//   rsp_valid/rsp_ready/rsp_*       response channel
//   busy                            FSM active or requests queued
module mul_seq_ctrl
    import mul_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OPW-1:0]   req_multiplier,
    input  logic [OPW-1:0]   req_multiplicand,
    input  logic [TAG_W-1:0] req_tag,
    output logic             op_start,
    output logic             op_clear,
    output logic [OPW-1:0]   multiplier,
    output logic [OPW-1:0]   multiplicand,
    input  logic             op_done,
    input  logic [RESW-1:0]  result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [RESW-1:0]  rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic             busy
);

    localparam int             CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT);

    seq_state_e       state;
    logic [WDW-1:0]   watchdog;
    logic [TAG_W-1:0] head_tag;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_push;
    logic             fifo_pop;
    logic             slot_free;

    assign req_ready = !fifo_full;
    assign fifo_push = req_valid && req_ready;
    assign fifo_pop  = (state == ST_CLEAR);
    assign slot_free = !rsp_valid || rsp_ready;
    assign busy      = (state != ST_IDLE) || (fifo_count != '0);

    mul_req_fifo #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk               (clk),
        .reset             (reset),
        .push              (fifo_push),
        .push_tag          (req_tag),
        .push_multiplicand (req_multiplicand),
        .push_multiplier   (req_multiplier),
        .pop               (fifo_pop),
        .head_tag          (head_tag),
        .head_multiplicand (multiplicand),
        .head_multiplier   (multiplier),
        .full              (fifo_full),
        .empty             (fifo_empty),
        .count             (fifo_count)
    );

    // Sequencer FSM with watchdog and response register. The watchdog is
    // zeroed as START is entered and counts the op_start cycle plus every
    // WAIT cycle, so an abort lands TIMEOUT+1 cycles after op_start rises.
    // While op_done is high but the response slot is still occupied the
    // count freezes: that stall is consumer backpressure, not a hang.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            watchdog   <= '0;
            op_start   <= 1'b0;
            op_clear   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_tag    <= '0;
            rsp_err    <= 1'b0;
        end else begin
            op_start <= 1'b0;
            op_clear <= 1'b0;
            if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state    <= ST_START;
                        op_start <= 1'b1;
                        watchdog <= '0;
                    end
                end
                ST_START: begin
                    state    <= ST_WAIT;
                    watchdog <= watchdog + 1'b1;
                end
                ST_WAIT: begin
                    if (op_done) begin
                        if (slot_free) begin
                            rsp_valid  <= 1'b1;
                            rsp_result <= result;
                            rsp_tag    <= head_tag;
                            rsp_err    <= 1'b0;
                            op_clear   <= 1'b1;
                            state      <= ST_CLEAR;
                        end
                    end else if (watchdog == WD_LIMIT) begin
                        if (slot_free) begin
                            rsp_valid  <= 1'b1;
                            rsp_result <= '0;
                            rsp_tag    <= head_tag;
                            rsp_err    <= 1'b1;
                            op_clear   <= 1'b1;
                            state      <= ST_CLEAR;
                        end
                    end else begin
                        watchdog <= watchdog + 1'b1;
                    end
                end
                ST_CLEAR: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
Upstream sequencer for the radix-2 Booth multiplier datapath (64x64 -> 128 signed). Accepts multiply requests over a valid/ready interface and buffers them in a small FIFO. Drives operands, start and clear to the multiplier, collects result/op_done, and returns tagged responses over a second valid/ready interface. Includes a watchdog that aborts a hung operation.

Parameters:
DEPTH, 2, request FIFO entries (power of two, >=2)
TAG_W, 4, request tag width
TIMEOUT, 100, max cycles from op_start to op_done before abort (< 2^16)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  FIFO not full
req_multiplier  in  64  signed operand B
req_multiplicand  in  64  signed operand A
req_tag  in  TAG_W  request identifier
op_start  out  1  one-cycle start pulse to multiplier
op_clear  out  1  one-cycle clear to multiplier
multiplier  out  64  held operand B (FIFO head)
multiplicand  out  64  held operand A (FIFO head)
op_done  in  1  multiplier finished; stays high until op_clear
result  in  128  multiplier product
rsp_valid  out  1  response held
rsp_ready  in  1  consumer accepts
rsp_result  out  128  product (0 on error)
rsp_tag  out  TAG_W  tag of the request
rsp_err  out  1  1 = watchdog abort
busy  out  1  FSM not IDLE or FIFO non-empty

Behaviour:
- Reset: FIFO empty, FSM IDLE, watchdog 0; op_start=0, op_clear=0, rsp_valid=0, rsp_result=0, rsp_tag=0, rsp_err=0, busy=0, req_ready=1. Reset mid-operation aborts silently with no response, and buffered requests are lost.
- FIFO: push on req_valid&&req_ready, pop only in CLEAR. Pointers wrap modulo DEPTH. Simultaneous push and pop when full is disallowed, because req_ready=!full is registered-count based. Push and pop together at count 1..DEPTH-1 leave the count unchanged.
- multiplier/multiplicand continuously show the FIFO head. They are stable from START through CLEAR because the head is not popped before then.
- FSM states: IDLE, START, WAIT, CLEAR.
  - IDLE: if FIFO non-empty -> START.
  - START: op_start=1 for exactly one cycle, watchdog cleared -> WAIT.
  - WAIT: the watchdog increments each cycle.
    - If op_done=1 and rsp slot free (!rsp_valid, or rsp_valid&&rsp_ready this cycle): load rsp_result=result, rsp_tag=head tag, rsp_err=0, set rsp_valid -> CLEAR.
    - If op_done=1 and the slot is occupied: stay in WAIT. The watchdog freezes (backpressure is not a timeout).
    - If watchdog==TIMEOUT and op_done=0: when the slot is free, load rsp_result=0, rsp_err=1 -> CLEAR.
  - CLEAR: op_clear=1 for one cycle, pop FIFO -> IDLE.
- rsp_valid stays high with stable data until rsp_ready. It drops the cycle after the handshake unless a new response loads on the same edge.
- Latency: accept at edge N into an empty, idle block -> op_start high in cycle N+2. op_done first seen high at edge M -> rsp_valid and op_clear high in cycle M+1. The next op_start comes no earlier than M+3.
- op_start and op_clear are never high in the same cycle.

Decomposition:
- Shared package mul_pkg: FSM state encoding (2-bit IDLE/START/WAIT/CLEAR), OPW=64, RESW=128, watchdog width 16.
- One sub-module, mul_req_fifo: a parameterised synchronous FIFO of {tag, multiplicand, multiplier} with full/empty/count outputs, clk and reset.
- The FSM, watchdog and response register live in mul_seq_ctrl.

Test Plan:
- Single request B=3, A=5, tag=1, with a behavioural multiplier model (op_done 65 cycles after op_start) -> rsp_result=15, tag=1, err=0. One op_start pulse and one op_clear pulse.
- Signed case: B=7, A=-2 (0xFFFF_FFFF_FFFF_FFFE) -> rsp_result=0xFFFF_..._FFF2 (128-bit -14). Operands stay stable on the multiplier ports from START to CLEAR.
- Three back-to-back requests with DEPTH=2 and rsp_ready=1 -> req_ready drops after two accepts. The third is accepted after the first CLEAR. Responses come in order with tags 0, 1, 2.
- rsp_ready=0 held for 20 cycles after the first response, with the second op_done already high -> FSM holds in WAIT with no op_clear and no timeout. On release, the second response follows immediately.
- op_done tied low, TIMEOUT=100 -> rsp_valid with rsp_err=1 and rsp_result=0, 101 cycles after op_start. op_clear then pulses and the next request starts.
- Assert reset in WAIT with 2 requests queued -> all outputs return to reset values asynchronously and stay idle. A new request after reset completes normally.
